// File: rtl/day11_query_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : day11_query_sequencer
// Brief    : Issues the seven (src,dst) table queries of one Day-11 solve to
//            the path-count engine and streams the counts to the accumulator.
// Revision : 1.0
// ============================================================================
module day11_query_sequencer #(
    parameter int NODE_W    = 10,
    parameter int COUNT_W   = 64,
    parameter int TIMEOUT_W = 20
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [NODE_W-1:0]  cfg_src,
    input  logic [NODE_W-1:0]  cfg_dst,
    output logic               eng_req,
    output logic [NODE_W-1:0]  eng_src,
    output logic [NODE_W-1:0]  eng_dst,
    input  logic               eng_ack,
    input  logic               eng_result_valid,
    input  logic [COUNT_W-1:0] eng_result,
    output logic               acc_load,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    output logic               count_last,
    input  logic               acc_ready,
    output logic               busy,
    output logic               done_,
    output logic               error,
    output logic [2:0]         idx
);

    localparam int                   NUM_ENTRIES = 7;
    localparam logic [2:0]           LAST_IDX    = 3'd6;
    localparam logic [TIMEOUT_W-1:0] TIMER_MAX   = {TIMEOUT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t               state_q;
    logic [2:0]           idx_q;
    logic [TIMEOUT_W-1:0] timer_q;
    logic [TIMEOUT_W-1:0] timer_d;
    logic [COUNT_W-1:0]   result_q;
    logic [NODE_W-1:0]    src_q [NUM_ENTRIES];
    logic [NODE_W-1:0]    dst_q [NUM_ENTRIES];
    logic                 eng_req_q;
    logic                 acc_load_q;
    logic                 count_valid_q;
    logic                 count_last_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 table_we_d;

    assign timer_d    = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMEOUT_W'(1);
    assign table_we_d = cfg_we && !busy_q;

    // Table is frozen for the whole run; idle writes land before LOAD reads them.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
            end
        end else if (table_we_d) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cfg_addr == 3'(i)) begin
                    src_q[i] <= cfg_src;
                    dst_q[i] <= cfg_dst;
                end
            end
        end
    end

    always_comb begin
        eng_src = '0;
        eng_dst = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (idx_q == 3'(i)) begin
                eng_src = src_q[i];
                eng_dst = dst_q[i];
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            result_q      <= '0;
            eng_req_q     <= 1'b0;
            acc_load_q    <= 1'b0;
            count_valid_q <= 1'b0;
            count_last_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            acc_load_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        idx_q      <= '0;
                        timer_q    <= '0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        acc_load_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q   <= S_ISSUE;
                    eng_req_q <= 1'b1;
                end
                S_ISSUE: begin
                    if (eng_ack) begin
                        state_q   <= S_WAIT;
                        eng_req_q <= 1'b0;
                        timer_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (eng_result_valid) begin
                        result_q      <= eng_result;
                        state_q       <= S_SEND;
                        count_valid_q <= 1'b1;
                        count_last_q  <= (idx_q == LAST_IDX);
                    end else begin
                        timer_q <= timer_d;
                        if (timer_d == TIMER_MAX) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_SEND: begin
                    if (acc_ready) begin
                        count_valid_q <= 1'b0;
                        count_last_q  <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            state_q   <= S_ISSUE;
                            eng_req_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    eng_req_q     <= 1'b0;
                    count_valid_q <= 1'b0;
                    count_last_q  <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign eng_req     = eng_req_q;
    assign acc_load    = acc_load_q;
    assign count       = result_q;
    assign count_valid = count_valid_q;
    assign count_last  = count_last_q;
    assign busy        = busy_q;
    assign done_       = done_q;
    assign error       = error_q;
    assign idx         = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_day11_query_sequencer.sv
`default_nettype none
// Bench for day11_query_sequencer: a scripted/random engine and accumulator
// model drives each run; expected beats come from the bench's own table.
module tb_day11_query_sequencer;

    localparam int NODE_W    = 10;
    localparam int COUNT_W   = 64;
    localparam int TIMEOUT_W = 4;

    logic               clock = 1'b0;
    logic               clear_n = 1'b0;
    logic               start = 1'b0;
    logic               cfg_we = 1'b0;
    logic [2:0]         cfg_addr = '0;
    logic [NODE_W-1:0]  cfg_src = '0;
    logic [NODE_W-1:0]  cfg_dst = '0;
    logic               eng_req;
    logic [NODE_W-1:0]  eng_src;
    logic [NODE_W-1:0]  eng_dst;
    logic               eng_ack = 1'b0;
    logic               eng_result_valid = 1'b0;
    logic [COUNT_W-1:0] eng_result = '0;
    logic               acc_load;
    logic [COUNT_W-1:0] count;
    logic               count_valid;
    logic               count_last;
    logic               acc_ready = 1'b0;
    logic               busy;
    logic               done_;
    logic               error;
    logic [2:0]         idx;

    int n_vec = 0;
    int n_err = 0;

    logic [NODE_W-1:0]  tbl_src [7];
    logic [NODE_W-1:0]  tbl_dst [7];
    logic [COUNT_W-1:0] res     [7];

    always #5 clock = ~clock;

    day11_query_sequencer #(
        .NODE_W   (NODE_W),
        .COUNT_W  (COUNT_W),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clock           (clock),
        .clear_n         (clear_n),
        .start           (start),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_src         (cfg_src),
        .cfg_dst         (cfg_dst),
        .eng_req         (eng_req),
        .eng_src         (eng_src),
        .eng_dst         (eng_dst),
        .eng_ack         (eng_ack),
        .eng_result_valid(eng_result_valid),
        .eng_result      (eng_result),
        .acc_load        (acc_load),
        .count           (count),
        .count_valid     (count_valid),
        .count_last      (count_last),
        .acc_ready       (acc_ready),
        .busy            (busy),
        .done_           (done_),
        .error           (error),
        .idx             (idx)
    );

    task automatic write_entry(input logic [2:0] a, input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] d);
        @(negedge clock);
        cfg_we = 1'b1; cfg_addr = a; cfg_src = s; cfg_dst = d;
        @(negedge clock);
        cfg_we = 1'b0;
        if (a != 3'd7) begin
            tbl_src[int'(a)] = s;
            tbl_dst[int'(a)] = d;
        end
    endtask

    task automatic load_scenario_table();
        for (int i = 0; i < 7; i++) begin
            int s;
            s = (i < 4) ? i : i + 1;
            write_entry(3'(i), NODE_W'(s), NODE_W'(s + 1));
        end
        res[0] = 64'd5; res[1] = 64'd2; res[2] = 64'd3; res[3] = 64'd4;
        res[4] = 64'd1; res[5] = 64'd1; res[6] = 64'd1;
    endtask

    // One run: start pulse, engine answering each query, accumulator taking beats.
    task automatic drive_run(input bit fixed_lat, input int ready_mode, input int silent_idx,
                             input int poke_idx, input int reset_idx, input bit wr0,
                             input logic [NODE_W-1:0] w_src, input logic [NODE_W-1:0] w_dst,
                             output int beats, output int gap);
        int q_k, beat_k, lat_cnt, stall_left, cyc, silent_ack;
        bit pend, prev_stall, poked, rdy;
        logic [COUNT_W-1:0] prev_count;
        logic [2:0] prev_idx;
        q_k = 0; beat_k = 0; lat_cnt = 0; stall_left = 4; silent_ack = -1;
        pend = 1'b0; prev_stall = 1'b0; poked = 1'b0; rdy = 1'b0;
        prev_count = '0; prev_idx = '0; gap = -1; beats = 0;
        eng_ack = 1'b0; eng_result_valid = 1'b0;
        @(negedge clock);
        start = 1'b1;
        if (wr0) begin
            cfg_we = 1'b1; cfg_addr = 3'd0; cfg_src = w_src; cfg_dst = w_dst;
            tbl_src[0] = w_src; tbl_dst[0] = w_dst;
        end
        @(negedge clock);
        start = 1'b0; cfg_we = 1'b0;
        n_vec++;
        if ({acc_load, busy, eng_req, done_, error, idx} !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL load_cycle: {acc_load,busy,eng_req,done,error,idx}=%b required 11000000",
                     {acc_load, busy, eng_req, done_, error, idx});
        end
        for (cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clock);
            eng_ack = 1'b0; eng_result_valid = 1'b0; eng_result = {$urandom, $urandom};
            acc_ready = 1'($urandom_range(0, 1)); start = 1'b0; cfg_we = 1'b0;
            if (!busy) break;
            n_vec++;
            if (acc_load !== 1'b0 || (cyc == 0 && eng_req !== 1'b1)) begin
                n_err++;
                $display("FAIL run_ctrl: cyc %0d acc_load=%b eng_req=%b required acc_load=0 (eng_req=1 at cyc 0)",
                         cyc, acc_load, eng_req);
            end
            if (prev_stall) begin
                n_vec++;
                if (count_valid !== 1'b1 || count !== prev_count || idx !== prev_idx) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b count=%0d idx=%0d required valid=1 count=%0d idx=%0d",
                             count_valid, count, idx, prev_count, prev_idx);
                end
            end
            if (reset_idx >= 0 && pend && q_k - 1 == reset_idx) begin
                #2 clear_n = 1'b0;
                #1;
                n_vec++;
                if ({eng_req, eng_src, eng_dst, acc_load, count, count_valid, count_last,
                     busy, done_, error, idx} !== '0) begin
                    n_err++;
                    $display("FAIL async_reset: outputs req=%b src=%0d dst=%0d load=%b count=%0d v=%b l=%b busy=%b done=%b err=%b idx=%0d required all 0",
                             eng_req, eng_src, eng_dst, acc_load, count, count_valid, count_last, busy, done_, error, idx);
                end
                beats = beat_k;
                return;
            end
            if (poke_idx >= 0 && pend && !poked && q_k - 1 == poke_idx) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_src = NODE_W'(9); cfg_dst = NODE_W'(9);
                poked = 1'b1;
            end
            if (eng_req) begin
                n_vec++;
                if (q_k > 6) begin
                    n_err++;
                    $display("FAIL query: extra query %0d required at most 7", q_k);
                end else if (eng_src !== tbl_src[q_k] || eng_dst !== tbl_dst[q_k] || idx !== 3'(q_k)) begin
                    n_err++;
                    $display("FAIL query: src=%0d dst=%0d idx=%0d required src=%0d dst=%0d idx=%0d",
                             eng_src, eng_dst, idx, tbl_src[q_k], tbl_dst[q_k], q_k);
                end
                eng_result_valid = 1'b1;
                if (fixed_lat || $urandom_range(0, 2) != 0) begin
                    eng_ack = 1'b1; pend = 1'b1;
                    lat_cnt = fixed_lat ? 3 : int'($urandom_range(1, 6));
                    if (q_k == silent_idx) silent_ack = cyc;
                    q_k++;
                end
            end else if (pend) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    pend = 1'b0;
                    if (q_k - 1 != silent_idx) begin
                        eng_result_valid = 1'b1;
                        eng_result = res[q_k - 1];
                    end
                end
            end
            if (count_valid) begin
                n_vec++;
                if (beat_k > 6) begin
                    n_err++;
                    $display("FAIL beat: extra beat %0d required 7 beats", beat_k);
                end else if (count !== res[beat_k] || count_last !== (beat_k == 6) || idx !== 3'(beat_k)) begin
                    n_err++;
                    $display("FAIL beat: count=%0d last=%b idx=%0d required count=%0d last=%b idx=%0d",
                             count, count_last, idx, res[beat_k], (beat_k == 6), beat_k);
                end
                if (ready_mode == 0) rdy = 1'b1;
                else if (ready_mode == 1) rdy = 1'($urandom_range(0, 1));
                else if (beat_k == 3 && stall_left > 0) begin rdy = 1'b0; stall_left--; end
                else rdy = 1'b1;
                acc_ready = rdy;
                if (rdy) beat_k++;
                eng_result_valid = 1'($urandom_range(0, 1));
                prev_stall = !rdy; prev_count = count; prev_idx = idx;
            end else begin
                prev_stall = 1'b0;
            end
        end
        if (cyc >= 2000) begin
            n_err++;
            $display("FAIL run_timeout: busy still %b after 2000 cycles required 0", busy);
        end
        beats = beat_k;
        if (silent_ack >= 0) gap = cyc - silent_ack;
    endtask

    task automatic check_done(input string tag, input int beats);
        n_vec++;
        if (beats !== 7 || {done_, error, busy, count_valid} !== 4'b1000 || count !== res[6]) begin
            n_err++;
            $display("FAIL %s_end: beats=%0d done/err/busy/valid=%b count=%0d required 7 1000 %0d",
                     tag, beats, {done_, error, busy, count_valid}, count, res[6]);
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({eng_req, eng_src, eng_dst, acc_load, count, count_valid, count_last, busy, done_, error, idx} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: nonzero outputs in reset, required all 0");
        end
        @(negedge clock);
        clear_n = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++;
        if ({busy, eng_req, done_, error, count_valid, idx} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_idle: busy/req/done/err/valid/idx=%b required 0", {busy, eng_req, done_, error, count_valid, idx});
        end
        for (int i = 0; i < 7; i++) begin tbl_src[i] = '0; tbl_dst[i] = '0; end
    endtask

    task automatic test_basic_run();
        int beats, gap;
        load_scenario_table();
        write_entry(3'd7, NODE_W'(1023), NODE_W'(1023));
        drive_run(1'b1, 0, -1, -1, -1, 1'b0, '0, '0, beats, gap);
        check_done("basic", beats);
        repeat (3) @(negedge clock);
        n_vec++;
        if (done_ !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_hold: done=%b busy=%b required 1 0", done_, busy);
        end
    endtask

    task automatic test_restart_from_done();
        int beats, gap;
        drive_run(1'b1, 0, -1, -1, -1, 1'b0, '0, '0, beats, gap);
        check_done("restart", beats);
    endtask

    task automatic test_backpressure();
        int beats, gap;
        drive_run(1'b1, 2, -1, -1, -1, 1'b0, '0, '0, beats, gap);
        check_done("backpressure", beats);
    endtask

    task automatic test_busy_ignore();
        int beats, gap;
        drive_run(1'b0, 1, -1, 2, -1, 1'b0, '0, '0, beats, gap);
        check_done("busy_ignore", beats);
        drive_run(1'b0, 1, -1, -1, -1, 1'b0, '0, '0, beats, gap);
        check_done("busy_ignore_rerun", beats);
    endtask

    task automatic test_timeout();
        int beats, gap;
        drive_run(1'b0, 1, 2, -1, -1, 1'b0, '0, '0, beats, gap);
        // Ack edge follows the driving cycle; the 15th edge after it raises error.
        n_vec++;
        if (beats !== 2 || gap !== 16 || {error, done_, busy, count_valid} !== 4'b1000) begin
            n_err++;
            $display("FAIL timeout: beats=%0d gap=%0d err/done/busy/valid=%b required 2 16 1000",
                     beats, gap, {error, done_, busy, count_valid});
        end
        repeat (3) @(negedge clock);
        n_vec++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL error_hold: error=%b busy=%b required 1 0", error, busy);
        end
    endtask

    task automatic test_start_with_write();
        int beats, gap;
        drive_run(1'b0, 1, -1, -1, -1, 1'b1, NODE_W'($urandom), NODE_W'($urandom), beats, gap);
        check_done("start_with_write", beats);
    endtask

    task automatic test_random();
        int beats, gap;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 7; i++) begin
                write_entry(3'(i), NODE_W'($urandom), NODE_W'($urandom));
                res[i] = {$urandom, $urandom};
            end
            drive_run(1'b0, 1, -1, -1, -1, 1'b0, '0, '0, beats, gap);
            check_done("random", beats);
        end
    endtask

    task automatic test_async_reset();
        int beats, gap;
        drive_run(1'b1, 0, -1, -1, 4, 1'b0, '0, '0, beats, gap);
        n_vec++;
        if (beats !== 4) begin
            n_err++;
            $display("FAIL reset_beats: beats=%0d required 4", beats);
        end
        @(negedge clock);
        clear_n = 1'b1;
        for (int i = 0; i < 7; i++) begin tbl_src[i] = '0; tbl_dst[i] = '0; end
        repeat (2) @(negedge clock);
        n_vec++;
        if ({busy, idx, eng_src, eng_dst, done_, error, count_valid, eng_req} !== '0) begin
            n_err++;
            $display("FAIL reset_release: busy=%b idx=%0d src=%0d dst=%0d done=%b err=%b valid=%b req=%b required all 0",
                     busy, idx, eng_src, eng_dst, done_, error, count_valid, eng_req);
        end
        load_scenario_table();
        drive_run(1'b0, 1, -1, -1, -1, 1'b0, '0, '0, beats, gap);
        check_done("post_reset", beats);
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_restart_from_done();
        test_backpressure();
        test_busy_ignore();
        test_timeout();
        test_start_with_write();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
